// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity modes and default bit timing.
package uart_pkg;

  localparam int CLK_HZ = 12_000_000;
  localparam int BAUD = 115_200;
  localparam int DEF_CLKS_PER_BIT = CLK_HZ / BAUD;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: ticks on the last clock of each serial bit.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  assign o_tick = (cnt == LAST) && !i_clear;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (i_clear || o_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_DEPTH = 8,
  parameter int PARITY_EN = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_DEPTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_tx,
  output logic                  o_done
);

  localparam int IW = $clog2(DATA_DEPTH);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_DEPTH - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic PAR_INV = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  uart_state_t state;
  logic [DATA_DEPTH-1:0] shreg;
  logic [IW-1:0] bit_idx;
  logic stop_idx;
  logic par;
  logic tick;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clear(state == ST_IDLE),
    .o_tick (tick)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
      shreg <= '0;
      bit_idx <= '0;
      stop_idx <= 1'b0;
      par <= 1'b0;
      o_tx <= 1'b1;
      o_ready <= 1'b1;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (i_valid && o_ready) begin
            shreg <= i_data;
            par <= (^i_data) ^ PAR_INV;
            o_tx <= 1'b0;
            o_ready <= 1'b0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            o_tx <= shreg[0];
            shreg <= shreg >> 1;
            bit_idx <= '0;
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
              stop_idx <= 1'b0;
              if (PARITY_EN != 0) begin
                o_tx <= par;
                state <= ST_PARITY;
              end else begin
                o_tx <= 1'b1;
                state <= ST_STOP;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              o_tx <= shreg[0];
              shreg <= shreg >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            o_tx <= 1'b1;
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (stop_idx == LAST_STOP) begin
              o_ready <= 1'b1;
              o_done <= 1'b1;
              state <= ST_IDLE;
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
        end
        default: begin
          o_tx <= 1'b1;
          o_ready <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover default, parity and stop-bit variants.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] valid = '0;
  logic [7:0] data [4];
  wire [3:0] tx, rdy, done;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(4)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_data(data[0]), .i_valid(valid[0]),
    .o_ready(rdy[0]), .o_tx(tx[0]), .o_done(done[0]));

  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_data(data[1]), .i_valid(valid[1]),
    .o_ready(rdy[1]), .o_tx(tx[1]), .o_done(done[1]));

  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_data(data[2]), .i_valid(valid[2]),
    .o_ready(rdy[2]), .o_tx(tx[2]), .o_done(done[2]));

  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_data(data[3]), .i_valid(valid[3]),
    .o_ready(rdy[3]), .o_tx(tx[3]), .o_done(done[3]));

  // Expected line level in cycle k after accept (k=1 is first start-bit cycle).
  function automatic logic exp_tx(logic [7:0] d, int k, int pe, int po);
    int idx;
    idx = (k - 1) / 4;
    if (k < 1) return 1'b1;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (pe != 0 && idx == 9) return (^d) ^ po[0];
    return 1'b1;
  endfunction

  task automatic send(input int u, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy[u] && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rdy[u] !== 1'b1) begin
      failures++;
      $display("FAIL send_ready u=%0d got=%b exp=1", u, rdy[u]);
    end
    valid[u] = 1'b1;
    data[u] = d;
    @(posedge clk);
    #1 valid[u] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 4; u++) begin
      checks += 3;
      if (tx[u] !== 1'b1) begin
        failures++;
        $display("FAIL reset_tx u=%0d got=%b exp=1", u, tx[u]);
      end
      if (rdy[u] !== 1'b1) begin
        failures++;
        $display("FAIL reset_ready u=%0d got=%b exp=1", u, rdy[u]);
      end
      if (done[u] !== 1'b0) begin
        failures++;
        $display("FAIL reset_done u=%0d got=%b exp=0", u, done[u]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_frame(input logic [7:0] d);
    send(0, d);
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      checks += 3;
      if (tx[0] !== exp_tx(d, k, 0, 0)) begin
        failures++;
        $display("FAIL frame_tx d=%h k=%0d got=%b exp=%b", d, k, tx[0], exp_tx(d, k, 0, 0));
      end
      if (rdy[0] !== (k == 41)) begin
        failures++;
        $display("FAIL frame_ready d=%h k=%0d got=%b exp=%b", d, k, rdy[0], k == 41);
      end
      if (done[0] !== (k == 41)) begin
        failures++;
        $display("FAIL frame_done d=%h k=%0d got=%b exp=%b", d, k, done[0], k == 41);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    @(negedge clk);
    valid[0] = 1'b1;
    data[0] = 8'h55;
    @(posedge clk);
    #1 data[0] = 8'hAA;
    for (int k = 1; k <= 82; k++) begin
      @(negedge clk);
      if (k == 42) valid[0] = 1'b0;
      e = (k <= 41) ? exp_tx(8'h55, k, 0, 0) : exp_tx(8'hAA, k - 41, 0, 0);
      checks += 2;
      if (tx[0] !== e) begin
        failures++;
        $display("FAIL b2b_tx k=%0d got=%b exp=%b", k, tx[0], e);
      end
      if (done[0] !== (k == 41 || k == 82)) begin
        failures++;
        $display("FAIL b2b_done k=%0d got=%b exp=%b", k, done[0], k == 41 || k == 82);
      end
    end
  endtask

  task automatic test_ignore();
    send(0, 8'h00);
    for (int k = 1; k <= 49; k++) begin
      @(negedge clk);
      if (k == 10) begin
        data[0] = 8'hFF;
        valid[0] = 1'b1;
      end
      if (k == 12) valid[0] = 1'b0;
      checks += 2;
      if (tx[0] !== exp_tx(8'h00, k, 0, 0)) begin
        failures++;
        $display("FAIL ignore_tx k=%0d got=%b exp=%b", k, tx[0], exp_tx(8'h00, k, 0, 0));
      end
      if (rdy[0] !== (k >= 41)) begin
        failures++;
        $display("FAIL ignore_ready k=%0d got=%b exp=%b", k, rdy[0], k >= 41);
      end
    end
  endtask

  task automatic test_reset_mid();
    send(0, 8'hC3);
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks += 3;
    if (tx[0] !== 1'b1) begin
      failures++;
      $display("FAIL midrst_tx got=%b exp=1", tx[0]);
    end
    if (rdy[0] !== 1'b1) begin
      failures++;
      $display("FAIL midrst_ready got=%b exp=1", rdy[0]);
    end
    if (done[0] !== 1'b0) begin
      failures++;
      $display("FAIL midrst_done got=%b exp=0", done[0]);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    valid[0] = 1'b1;
    data[0] = 8'h31;
    @(posedge clk);
    #1 valid[0] = 1'b0;
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      checks += 2;
      if (tx[0] !== exp_tx(8'h31, k, 0, 0)) begin
        failures++;
        $display("FAIL midrst_frame_tx k=%0d got=%b exp=%b", k, tx[0], exp_tx(8'h31, k, 0, 0));
      end
      if (done[0] !== (k == 41)) begin
        failures++;
        $display("FAIL midrst_frame_done k=%0d got=%b exp=%b", k, done[0], k == 41);
      end
    end
  endtask

  task automatic test_parity();
    for (int u = 1; u <= 2; u++) begin
      send(u, 8'h07);
      for (int k = 1; k <= 45; k++) begin
        @(negedge clk);
        checks += 2;
        if (tx[u] !== exp_tx(8'h07, k, 1, u - 1)) begin
          failures++;
          $display("FAIL parity_tx u=%0d k=%0d got=%b exp=%b", u, k, tx[u], exp_tx(8'h07, k, 1, u - 1));
        end
        if (done[u] !== (k == 45)) begin
          failures++;
          $display("FAIL parity_done u=%0d k=%0d got=%b exp=%b", u, k, done[u], k == 45);
        end
      end
    end
  endtask

  task automatic test_stop2();
    send(3, 8'hFF);
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      checks += 3;
      if (tx[3] !== exp_tx(8'hFF, k, 0, 0)) begin
        failures++;
        $display("FAIL stop2_tx k=%0d got=%b exp=%b", k, tx[3], exp_tx(8'hFF, k, 0, 0));
      end
      if (rdy[3] !== (k == 45)) begin
        failures++;
        $display("FAIL stop2_ready k=%0d got=%b exp=%b", k, rdy[3], k == 45);
      end
      if (done[3] !== (k == 45)) begin
        failures++;
        $display("FAIL stop2_done k=%0d got=%b exp=%b", k, done[3], k == 45);
      end
    end
  endtask

  initial begin
    for (int u = 0; u < 4; u++) data[u] = 8'h00;
    test_reset();
    test_frame(8'h61);
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    test_parity();
    test_stop2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
